// File: rtl/usb_pkg.sv
// usb_pkg: packet codes, scheduler states and the payload size limit
// shared by the USB transmit scheduler files.
package usb_pkg;
    localparam int MAX_SIZE = 64;
    typedef enum logic [1:0] {
        PKT_ACK  = 2'b00,
        PKT_NACK = 2'b01,
        PKT_DATA = 2'b10,
        PKT_IDLE = 2'b11
    } pkt_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACTIVE,
        S_GAP
    } state_t;
endpackage

// File: rtl/usb_sched_timer.sv
// usb_sched_timer: loadable down-counter, saturating at zero, used for the
// issue timeout and the inter-packet gap.
module usb_sched_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: latches handshake/DATA requests and issues them to the USB transmitter.
// Define USB_TX_SCHED_GAP_EN for an IPG_CYCLES inter-packet gap (otherwise one cycle).
module usb_tx_scheduler #(
    parameter int MAX_SIZE      = usb_pkg::MAX_SIZE,
    parameter int START_TIMEOUT = 8,
    parameter int IPG_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic       hs_nak,
    input  logic       data_req,
    input  logic [6:0] data_size,
    input  logic [7:0] buf_rdata,
    output logic       buf_rd,
    output logic [1:0] tx_packet,
    output logic [7:0] tx_packet_data,
    output logic [6:0] tx_packet_data_size,
    input  logic       get_tx_packet_data,
    input  logic       tx_busy,
    output logic       hs_pending,
    output logic       data_pending,
    output logic       hs_done,
    output logic       data_done,
    output logic       err,
    output logic       sched_busy
);
    import usb_pkg::*;
    localparam int TW = $clog2((START_TIMEOUT > IPG_CYCLES ? START_TIMEOUT : IPG_CYCLES) + 1);
    state_t state, state_d;
    logic hs_nak_q, sel_hs, load, zero;
    logic [6:0] size_q, cur_size, cnt;
    logic [TW-1:0] load_val;
    logic hs_acc, data_ok, data_acc, issue_go, timeout, fin, data_act, fetch_ok, over_fetch, err_d;
    always_comb begin
        hs_acc     = hs_req & ~hs_pending;
        data_ok    = data_size != 7'd0 && int'(data_size) <= MAX_SIZE;
        data_acc   = data_req & ~data_pending & data_ok;
        issue_go   = state == S_ISSUE && tx_busy;
        timeout    = state == S_ISSUE && !tx_busy && zero;
        fin        = state == S_ACTIVE && !tx_busy;
        data_act   = state == S_ACTIVE && !sel_hs;
        fetch_ok   = data_act && get_tx_packet_data && cnt < cur_size;
        over_fetch = data_act && get_tx_packet_data && cnt >= cur_size;
        err_d      = (hs_req & hs_pending) | (data_req & ~data_acc) | timeout | over_fetch
                   | (fin & ~sel_hs & (cnt != cur_size));
    end
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   state_d = (hs_pending | data_pending) ? S_ISSUE : S_IDLE;
            S_ISSUE:  state_d = tx_busy ? S_ACTIVE : (zero ? S_GAP : S_ISSUE);
            S_ACTIVE: state_d = tx_busy ? S_ACTIVE : S_GAP;
`ifdef USB_TX_SCHED_GAP_EN
            S_GAP:    state_d = zero ? S_IDLE : S_GAP;
`else
            S_GAP:    state_d = S_IDLE;
`endif
        endcase
        load                = state_d != state;
        load_val            = state_d == S_ISSUE ? TW'(START_TIMEOUT - 1) : TW'(IPG_CYCLES - 1);
        tx_packet           = state == S_ISSUE ? (sel_hs ? (hs_nak_q ? PKT_NACK : PKT_ACK) : PKT_DATA) : PKT_IDLE;
        tx_packet_data_size = (state == S_ISSUE && !sel_hs) ? size_q : 7'd0;
        tx_packet_data      = data_act ? buf_rdata : 8'd0;
        buf_rd              = fetch_ok;
        sched_busy          = state != S_IDLE;
    end
    usb_sched_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            hs_pending   <= 1'b0;
            data_pending <= 1'b0;
            hs_nak_q     <= 1'b0;
            size_q       <= 7'd0;
            cur_size     <= 7'd0;
            cnt          <= 7'd0;
            sel_hs       <= 1'b0;
            hs_done      <= 1'b0;
            data_done    <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            hs_pending   <= hs_acc | (hs_pending & ~(issue_go & sel_hs));
            data_pending <= data_acc | (data_pending & ~(issue_go & ~sel_hs));
            if (hs_acc) hs_nak_q <= hs_nak;
            if (data_acc) size_q <= data_size;
            // a handshake accepted this cycle still outranks an older data request
            if (state == S_IDLE) sel_hs <= hs_pending | hs_acc;
            if (issue_go) begin
                cur_size <= size_q;
                cnt      <= 7'd0;
            end else if (fetch_ok) cnt <= cnt + 7'd1;
            hs_done   <= fin & sel_hs;
            data_done <= fin & ~sel_hs;
            err       <= err_d;
        end
    end
endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb_usb_tx_scheduler: directed checks of the USB transmit scheduler.
// Inputs change and outputs are checked just after the falling clock edge.
module tb_usb_tx_scheduler;
`ifdef USB_TX_SCHED_GAP_EN
    localparam int GAP = 16;
`else
    localparam int GAP = 1;
`endif
    logic tb_clk = 1'b0;
    logic rst = 1'b1, hs_req = 1'b0, hs_nak = 1'b0, data_req = 1'b0;
    logic get_tx_packet_data = 1'b0, tx_busy = 1'b0;
    logic [6:0] data_size = 7'd0;
    logic [7:0] buf_rdata = 8'd0;
    logic buf_rd, hs_pending, data_pending, hs_done, data_done, err, sched_busy;
    logic [1:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] tx_packet_data_size;
    int checks = 0, failures = 0;
    int n_err = 0, n_rd = 0, n_hd = 0, n_dd = 0;
    int e0, r0, h0, d0, n;

    usb_tx_scheduler dut (
        .clk                 (tb_clk),
        .rst                 (rst),
        .hs_req              (hs_req),
        .hs_nak              (hs_nak),
        .data_req            (data_req),
        .data_size           (data_size),
        .buf_rdata           (buf_rdata),
        .buf_rd              (buf_rd),
        .tx_packet           (tx_packet),
        .tx_packet_data      (tx_packet_data),
        .tx_packet_data_size (tx_packet_data_size),
        .get_tx_packet_data  (get_tx_packet_data),
        .tx_busy             (tx_busy),
        .hs_pending          (hs_pending),
        .data_pending        (data_pending),
        .hs_done             (hs_done),
        .data_done           (data_done),
        .err                 (err),
        .sched_busy          (sched_busy)
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) begin
        if (!rst) begin
            n_err += int'(err);
            n_rd  += int'(buf_rd);
            n_hd  += int'(hs_done);
            n_dd  += int'(data_done);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge tb_clk);
        #1;
    endtask

    task automatic wait_pkt(input int code, input string tag);
        int k = 0;
        while (int'(tx_packet) != code && k < 60) begin
            nxt();
            k++;
        end
        chk(tag, int'(tx_packet), code);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (sched_busy && k < 60) begin
            nxt();
            k++;
        end
        chk(tag, int'(sched_busy), 0);
    endtask

    task automatic snap();
        e0 = n_err; r0 = n_rd; h0 = n_hd; d0 = n_dd;
    endtask

    initial begin
        nxt();
        chk("rst_pkt", int'(tx_packet), 3);
        chk("rst_size", int'(tx_packet_data_size), 0);
        chk("rst_busy", int'(sched_busy), 0);
        chk("rst_pend", int'({hs_pending, data_pending}), 0);
        rst = 1'b0;
        nxt();

        // ACK handshake, transmitter busy for 30 cycles
        snap();
        hs_req = 1'b1; hs_nak = 1'b0;
        nxt();
        hs_req = 1'b0;
        chk("ack_pend", int'(hs_pending), 1);
        nxt();
        chk("ack_issue1", int'(tx_packet), 0);
        nxt();
        chk("ack_issue2", int'(tx_packet), 0);
        tx_busy = 1'b1;
        nxt();
        chk("ack_active_pkt", int'(tx_packet), 3);
        chk("ack_pend_clr", int'(hs_pending), 0);
        repeat (29) nxt();
        tx_busy = 1'b0;
        nxt();
        chk("ack_done", int'(hs_done), 1);
        n = 0;
        while (sched_busy && n < 100) begin
            n++;
            nxt();
        end
        chk("gap_len", n, GAP);
        chk("ack_done_cnt", n_hd - h0, 1);
        chk("ack_err_cnt", n_err - e0, 0);

        // simultaneous NACK and DATA(4): handshake first
        snap();
        hs_req = 1'b1; hs_nak = 1'b1; data_req = 1'b1; data_size = 7'd4;
        nxt();
        hs_req = 1'b0; data_req = 1'b0;
        chk("both_pend", int'({hs_pending, data_pending}), 3);
        nxt();
        chk("nack_pkt", int'(tx_packet), 1);
        chk("nack_size", int'(tx_packet_data_size), 0);
        tx_busy = 1'b1;
        nxt();
        tx_busy = 1'b0;
        chk("data_still_pend", int'(data_pending), 1);
        nxt();
        chk("nack_done", int'(hs_done), 1);
        wait_pkt(2, "data_pkt");
        chk("data_size4", int'(tx_packet_data_size), 4);
        tx_busy = 1'b1;
        nxt();
        for (int i = 0; i < 4; i++) begin
            buf_rdata = 8'(8'h5A + i * 17);
            get_tx_packet_data = 1'b1;
            #1;
            chk("byte_pass", int'(tx_packet_data), 8'h5A + i * 17);
            chk("byte_rd", int'(buf_rd), 1);
            nxt();
        end
        get_tx_packet_data = 1'b0; tx_busy = 1'b0;
        nxt();
        chk("data_done", int'(data_done), 1);
        wait_idle("data_idle");
        chk("data_rd_cnt", n_rd - r0, 4);
        chk("data_done_cnt", n_dd - d0, 1);
        chk("data_err_cnt", n_err - e0, 0);

        // illegal sizes rejected
        snap();
        data_req = 1'b1; data_size = 7'd0;
        nxt();
        data_size = 7'd65;
        nxt();
        data_req = 1'b0;
        nxt();
        chk("bad_size_err", n_err - e0, 2);
        chk("bad_size_pend", int'(data_pending), 0);
        chk("bad_size_idle", int'(sched_busy), 0);

        // start timeout, then re-issue
        snap();
        hs_req = 1'b1; hs_nak = 1'b0;
        nxt();
        hs_req = 1'b0;
        wait_pkt(0, "to_issue");
        n = 0;
        while (tx_packet == 2'b00 && n < 50) begin
            n++;
            nxt();
        end
        chk("to_cycles", n, 8);
        chk("to_err", int'(err), 1);
        chk("to_pend", int'(hs_pending), 1);
        wait_pkt(0, "to_reissue");
        tx_busy = 1'b1;
        nxt();
        tx_busy = 1'b0;
        nxt();
        chk("to_done", int'(hs_done), 1);
        chk("to_pend_clr", int'(hs_pending), 0);
        wait_idle("to_idle");
        chk("to_err_cnt", n_err - e0, 1);

        // over-fetch on a 2-byte packet
        snap();
        data_req = 1'b1; data_size = 7'd2;
        nxt();
        data_req = 1'b0;
        wait_pkt(2, "of_pkt");
        chk("of_size", int'(tx_packet_data_size), 2);
        tx_busy = 1'b1;
        nxt();
        get_tx_packet_data = 1'b1;
        #1;
        chk("of_rd1", int'(buf_rd), 1);
        nxt();
        chk("of_rd2", int'(buf_rd), 1);
        nxt();
        chk("of_rd3", int'(buf_rd), 0);
        nxt();
        get_tx_packet_data = 1'b0;
        chk("of_err", int'(err), 1);
        tx_busy = 1'b0;
        nxt();
        chk("of_done", int'(data_done), 1);
        chk("of_end_err", int'(err), 0);
        wait_idle("of_idle");
        chk("of_rd_cnt", n_rd - r0, 2);
        chk("of_err_cnt", n_err - e0, 1);

        // short packet: 1 of 3 bytes fetched
        snap();
        data_req = 1'b1; data_size = 7'd3;
        nxt();
        data_req = 1'b0;
        wait_pkt(2, "sh_pkt");
        tx_busy = 1'b1;
        nxt();
        get_tx_packet_data = 1'b1;
        nxt();
        get_tx_packet_data = 1'b0; tx_busy = 1'b0;
        nxt();
        chk("sh_done", int'(data_done), 1);
        chk("sh_err", int'(err), 1);
        wait_idle("sh_idle");

        // reset in the middle of a DATA packet
        data_req = 1'b1; data_size = 7'd8;
        nxt();
        data_req = 1'b0;
        wait_pkt(2, "rm_pkt");
        tx_busy = 1'b1;
        nxt();
        get_tx_packet_data = 1'b1;
        #1;
        chk("rm_rd_pre", int'(buf_rd), 1);
        rst = 1'b1;
        #1;
        chk("rm_rd", int'(buf_rd), 0);
        chk("rm_pkt_idle", int'(tx_packet), 3);
        chk("rm_size", int'(tx_packet_data_size), 0);
        chk("rm_busy", int'(sched_busy), 0);
        chk("rm_pulses", int'({hs_done, data_done, err}), 0);
        chk("rm_pend", int'({hs_pending, data_pending}), 0);
        nxt();
        rst = 1'b0; tx_busy = 1'b0; get_tx_packet_data = 1'b0;
        nxt();
        chk("rm_after_busy", int'(sched_busy), 0);
        chk("rm_after_pkt", int'(tx_packet), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_tx_scheduler.md
USB_TX_SCHEDULER -- requirements
Module: usb_tx_scheduler

Interface
REQ-001 The block SHALL have the parameter MAX_SIZE, default 64, giving the largest legal DATA payload in bytes.
REQ-002 The block SHALL have the parameter START_TIMEOUT, default 8, giving the maximum cycles from issue to tx_busy rising.
REQ-003 The block SHALL have the parameter IPG_CYCLES, default 16, giving the minimum idle cycles between packets.
REQ-004 The block SHALL have the port clk  in  1  system clock, rising edge.
REQ-005 The block SHALL have the port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have the port hs_req  in  1  one-cycle request to send a handshake.
REQ-007 The block SHALL have the port hs_nak  in  1  handshake type, sampled with hs_req (0=ACK, 1=NACK).
REQ-008 The block SHALL have the port data_req  in  1  one-cycle request to send a DATA packet.
REQ-009 The block SHALL have the port data_size  in  7  payload bytes, sampled with data_req.
REQ-010 The block SHALL have the port buf_rdata  in  8  head byte of the external payload buffer.
REQ-011 The block SHALL have the port buf_rd  out  1  buffer pop strobe.
REQ-012 The block SHALL have the port tx_packet  out  2  packet code to the transmitter (ACK=00, NACK=01, DATA=10, IDLE=11).
REQ-013 The block SHALL have the port tx_packet_data  out  8  payload byte to the transmitter.
REQ-014 The block SHALL have the port tx_packet_data_size  out  7  payload length to the transmitter.
REQ-015 The block SHALL have the port get_tx_packet_data  in  1  transmitter byte-fetch strobe.
REQ-016 The block SHALL have the port tx_busy  in  1  transmitter busy.
REQ-017 The block SHALL have the ports hs_pending, data_pending  out  1 each  latched requests not yet issued.
REQ-018 The block SHALL have the ports hs_done, data_done  out  1 each  one-cycle completion pulses.
REQ-019 The block SHALL have the ports err  out  1 (one-cycle error pulse) and sched_busy  out  1 (state not IDLE).

Function
REQ-020 hs_req SHALL set hs_pending and latch hs_nak; data_req SHALL set data_pending and latch data_size.
REQ-021 A request arriving while its own pending flag is set SHALL be dropped and SHALL pulse err; the latched values are kept.
REQ-022 data_req with data_size of 0 or greater than MAX_SIZE SHALL be rejected with an err pulse and no pending flag.
REQ-023 The FSM states SHALL be IDLE, ISSUE, ACTIVE and GAP.
REQ-024 IDLE->ISSUE SHALL occur when any request is pending; handshake SHALL take priority over data, including requests arriving in the same cycle.
REQ-025 In ISSUE, tx_packet SHALL hold the selected code and tx_packet_data_size the latched size (0 for handshakes) until tx_busy is sampled high; the FSM then goes to ACTIVE and the issued pending flag clears.
REQ-026 If tx_busy does not rise within START_TIMEOUT cycles of entering ISSUE, the block SHALL pulse err, keep the request pending and go to GAP.
REQ-027 Outside ISSUE, tx_packet SHALL be 11 (IDLE).
REQ-028 During a DATA packet, tx_packet_data SHALL equal buf_rdata combinationally, and buf_rd SHALL equal get_tx_packet_data.
REQ-029 A 7-bit byte counter SHALL count fetches; fetches beyond the latched size SHALL pulse err and SHALL NOT assert buf_rd.
REQ-030 Outside a DATA packet, buf_rd SHALL be 0 and get_tx_packet_data SHALL be ignored.
REQ-031 The tx_busy falling edge in ACTIVE SHALL pulse hs_done or data_done in the next cycle and SHALL move the FSM to GAP.
REQ-032 A data packet that ends with the fetch count not equal to the size SHALL also pulse err.

Reset
REQ-033 Asserting rst SHALL force IDLE, clear all pending flags and counters, and set tx_packet=11, tx_packet_data_size=0, buf_rd=0, all pulses=0 and sched_busy=0, including mid-packet.

Configuration
REQ-034 With USB_TX_SCHED_GAP_EN defined, GAP SHALL last exactly IPG_CYCLES cycles before returning to IDLE.
REQ-035 Without USB_TX_SCHED_GAP_EN, GAP SHALL last one cycle.

Structure
REQ-036 The packet-code typedef (ACK, NACK, DATA, IDLE), the FSM state typedef and MAX_SIZE SHALL reside in a shared package, usb_pkg.
REQ-037 The gap/timeout down-counter SHALL be a sub-module, usb_sched_timer.

Verification
REQ-038 hs_req with hs_nak=0, tx_busy raised 2 cycles later and held for 30 cycles -> tx_packet=00 until busy, then 11; hs_done pulses once.
REQ-039 hs_req with hs_nak=1 and data_req with size 4 in the same cycle -> NACK (01) issued first; DATA (10, size 4) issued after GAP; 4 buf_rd pulses; data_done pulses.
REQ-040 data_req with size 0, then with size 65 -> two err pulses; data_pending stays 0.
REQ-041 hs_req, tx_busy never rises -> err after 8 cycles; hs_pending stays 1; request re-issues.
REQ-042 data_req with size 2, 3 fetch strobes -> 2 buf_rd pulses; err on the third fetch.
REQ-043 rst asserted mid-DATA -> all outputs at reset values immediately; GAP length checked at 16 cycles with USB_TX_SCHED_GAP_EN and 1 cycle without it.
